// File: rtl/uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StStart,
        StData,
        StParity,
        StStop
    } uart_state_e;

    localparam logic UART_IDLE_LVL = 1'b1;
    localparam logic START_LVL     = 1'b0;

    localparam int unsigned FRAME_BITS_8N1 = 10;
    localparam int unsigned FRAME_BITS_8E1 = 11;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period timer: counts enabled cycles and pulses bit_done_o on the last cycle of a bit.
module uart_baud_cnt #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic bit_done_o
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign bit_done_o = enable_i && (cnt_q == CntMax);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = bit_done_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a byte FIFO into LSB-first UART frames (8N1; even parity bit added when
// UART_TX_PARITY_EN is defined). All outputs are registered.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fifo_empty,
    input  logic                 fifo_full,
    input  logic                 fifo_wr,
    input  logic [DATA_BITS-1:0] fifo_dout,
    output logic                 fifo_rd,
    output logic                 tx,
    output logic                 busy
);

    localparam int unsigned IdxW = $clog2(DATA_BITS);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_BITS - 1);

    uart_state_e          state_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [IdxW-1:0]      idx_q;
    logic                 tx_q;
    logic                 busy_q;
    logic                 rd_q;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q;
`endif

    logic rd_acc;
    logic baud_clr;
    logic baud_en;
    logic bit_done;

    // A simultaneous producer write wins inside the FIFO, so the read is not taken.
    assign rd_acc = rd_q & ~fifo_empty & ~(fifo_wr & ~fifo_full);

    always_comb begin
        baud_clr = (state_q == StLoad);
        baud_en  = (state_q == StStart) || (state_q == StData) ||
                   (state_q == StParity) || (state_q == StStop);
    end

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (baud_clr),
        .enable_i  (baud_en),
        .bit_done_o(bit_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            shift_q  <= '0;
            idx_q    <= '0;
            tx_q     <= UART_IDLE_LVL;
            busy_q   <= 1'b0;
            rd_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!fifo_empty) begin
                        state_q <= StFetch;
                        rd_q    <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                StFetch: begin
                    if (rd_acc) begin
                        state_q <= StLoad;
                        rd_q    <= 1'b0;
                    end
                end
                StLoad: begin
                    shift_q  <= fifo_dout;
                    idx_q    <= '0;
                    tx_q     <= START_LVL;
                    state_q  <= StStart;
`ifdef UART_TX_PARITY_EN
                    parity_q <= ^fifo_dout;
`endif
                end
                StStart: begin
                    if (bit_done) begin
                        tx_q    <= shift_q[0];
                        state_q <= StData;
                    end
                end
                StData: begin
                    if (bit_done) begin
                        shift_q <= shift_q >> 1;
                        if (idx_q == LastIdx) begin
`ifdef UART_TX_PARITY_EN
                            tx_q    <= parity_q;
                            state_q <= StParity;
`else
                            tx_q    <= UART_IDLE_LVL;
                            state_q <= StStop;
`endif
                        end else begin
                            idx_q <= idx_q + 1'b1;
                            tx_q  <= shift_q[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                StParity: begin
                    if (bit_done) begin
                        tx_q    <= UART_IDLE_LVL;
                        state_q <= StStop;
                    end
                end
`endif
                StStop: begin
                    if (bit_done) begin
                        // Chain straight into the next frame when more data is waiting.
                        if (!fifo_empty) begin
                            state_q <= StFetch;
                            rd_q    <= 1'b1;
                        end else begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    tx_q    <= UART_IDLE_LVL;
                    busy_q  <= 1'b0;
                    rd_q    <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_rd = rd_q;
    assign tx      = tx_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: behavioural 16-deep FIFO (write priority) feeding the DUT,
// table of bytes with hand-derived frames, plus reset, back-to-back and collision runs.
`timescale 1ns/1ps
module tb_fifo_uart_tx;

    localparam int unsigned CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int NV = 7;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;  // frame[k] = line level of bit slot k: start, d0..d7, stop
        logic       par;
    } vec_t;

    vec_t vecs[NV];

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fifo_wr = 1'b0;
    logic [7:0] fifo_din = 8'h00;
    logic [7:0] fifo_dout = 8'h00;
    logic       fifo_empty;
    logic       fifo_full;
    logic       fifo_rd;
    logic       tx;
    logic       busy;

    int total = 0;
    int bad = 0;

    // FIFO model: write has priority, read data registered.
    logic [7:0] mem [16];
    logic [3:0] wp = 4'd0;
    logic [3:0] rp = 4'd0;
    logic [4:0] cnt = 5'd0;

    assign fifo_empty = (cnt == 5'd0);
    assign fifo_full  = (cnt == 5'd16);

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fifo_wr && !fifo_full) begin
            mem[wp] <= fifo_din;
            wp      <= wp + 4'd1;
            cnt     <= cnt + 5'd1;
        end else if (fifo_rd && !fifo_empty) begin
            fifo_dout <= mem[rp];
            rp        <= rp + 4'd1;
            cnt       <= cnt - 5'd1;
        end
    end

    fifo_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fifo_empty(fifo_empty),
        .fifo_full (fifo_full),
        .fifo_wr   (fifo_wr),
        .fifo_dout (fifo_dout),
        .fifo_rd   (fifo_rd),
        .tx        (tx),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic got, input logic exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%b exp=%b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic exp_bit(input int vi, input int b);
`ifdef UART_TX_PARITY_EN
        if (b == 9) return vecs[vi].par;
        if (b == 10) return vecs[vi].frame[9];
`endif
        return vecs[vi].frame[b];
    endfunction

    task automatic push(input logic [7:0] b);
        fifo_wr  = 1'b1;
        fifo_din = b;
        @(negedge clk);
        fifo_wr  = 1'b0;
    endtask

    task automatic wait_rd();
        int n = 0;
        while (!fifo_rd && n < 30) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Entered at the negedge where fifo_rd is first high; returns one cycle after the stop bit.
    task automatic check_frame(input int vi, input int exp_rd, input string tag);
        int rd_cnt = 0;
        chk({tag, " fetch_rd"}, fifo_rd, 1'b1);
        chk({tag, " fetch_tx"}, tx, 1'b1);
        while (fifo_rd && rd_cnt < 20) begin
            rd_cnt++;
            @(negedge clk);
        end
        chk_int({tag, " rd_cycles"}, rd_cnt, exp_rd);
        chk({tag, " load_tx"}, tx, 1'b1);
        chk({tag, " load_busy"}, busy, 1'b1);
        @(negedge clk);
        for (int b = 0; b < NB; b++) begin
            chk($sformatf("%s busy slot%0d", tag, b), busy, 1'b1);
            for (int c = 0; c < int'(CPB); c++) begin
                chk($sformatf("%s tx slot%0d c%0d", tag, b, c), tx, exp_bit(vi, b));
                @(negedge clk);
            end
        end
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, " idle_busy"}, busy, 1'b0);
        chk({tag, " idle_rd"}, fifo_rd, 1'b0);
        chk({tag, " idle_tx"}, tx, 1'b1);
        chk({tag, " fifo_empty"}, fifo_empty, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{data: 8'hA5, frame: 10'b1101001010, par: 1'b0};
        vecs[1] = '{data: 8'h00, frame: 10'b1000000000, par: 1'b0};
        vecs[2] = '{data: 8'hFF, frame: 10'b1111111110, par: 1'b0};
        vecs[3] = '{data: 8'h3C, frame: 10'b1001111000, par: 1'b0};
        vecs[4] = '{data: 8'h81, frame: 10'b1100000010, par: 1'b0};
        vecs[5] = '{data: 8'h07, frame: 10'b1000001110, par: 1'b1};
        vecs[6] = '{data: 8'h03, frame: 10'b1000000110, par: 1'b0};

        // Reset held with empty FIFO
        rst = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("rst tx", tx, 1'b1);
            chk("rst busy", busy, 1'b0);
            chk("rst rd", fifo_rd, 1'b0);
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            idle_chk("post_rst");
        end

        // Single frames from the table
        for (int vi = 0; vi < NV; vi++) begin
            push(vecs[vi].data);
            wait_rd();
            check_frame(vi, 1, $sformatf("single%0d", vi));
            idle_chk($sformatf("single%0d", vi));
            @(negedge clk);
        end

        // Back-to-back: preload three bytes while held in reset
        rst = 1'b1;
        push(vecs[1].data);
        push(vecs[2].data);
        push(vecs[3].data);
        rst = 1'b0;
        wait_rd();
        for (int vi = 1; vi <= 3; vi++) begin
            check_frame(vi, 1, $sformatf("b2b%0d", vi));
        end
        idle_chk("b2b");
        @(negedge clk);

        // Reset during data bit 3 of 0x81, then 0x3C follows
        rst = 1'b1;
        push(vecs[4].data);
        push(vecs[3].data);
        rst = 1'b0;
        wait_rd();
        chk("midrst rd", fifo_rd, 1'b1);
        @(negedge clk);
        @(negedge clk);
        repeat (17) @(negedge clk);
        chk("midrst bit3", tx, 1'b0);
        chk("midrst busy_pre", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst tx", tx, 1'b1);
        chk("midrst busy", busy, 1'b0);
        chk("midrst rd", fifo_rd, 1'b0);
        rst = 1'b0;
        wait_rd();
        check_frame(3, 1, "after_rst");
        idle_chk("after_rst");
        @(negedge clk);

        // Write collision: producer writes for 5 FETCH cycles
        push(vecs[0].data);
        wait_rd();
        fork
            begin
                for (int k = 0; k < 5; k++) begin
                    fifo_wr  = 1'b1;
                    fifo_din = vecs[k + 1].data;
                    @(negedge clk);
                end
                fifo_wr = 1'b0;
            end
            check_frame(0, 6, "coll");
        join
        for (int k = 0; k < 5; k++) begin
            check_frame(k + 1, 1, $sformatf("coll_q%0d", k));
        end
        idle_chk("coll");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Downstream consumer of the 8-bit, 16-deep byte FIFO. Pops one byte at a time from the FIFO and serializes it as an asynchronous UART frame: 8N1 by default, LSB first. Sits between the FIFO read port and the board TX pin. Drains the FIFO continuously while the FIFO is non-empty.

Parameters:
CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); legal range >= 2
DATA_BITS, 8, payload bits per frame; fixed to match the FIFO width

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  synchronous, active-high reset
fifo_empty  input  1  FIFO empty flag
fifo_full  input  1  FIFO full flag
fifo_wr  input  1  FIFO write strobe, tapped from the producer; used to detect read suppression
fifo_dout  input  8  FIFO registered read data
fifo_rd  output  1  FIFO read strobe
tx  output  1  serial line, idle high
busy  output  1  high from the fetch until the end of the stop bit

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: tx=1, busy=0, fifo_rd=0, state=IDLE, baud counter=0, bit index=0.
- FIFO semantics the block relies on:
  - A write has priority over a read in the FIFO.
  - A read is accepted only when rd_acc = fifo_rd & ~fifo_empty & ~(fifo_wr & ~fifo_full).
  - fifo_dout holds the accepted byte from the cycle after acceptance.
- fifo_rd is a Moore output and is high only in FETCH.
- State machine:
  - IDLE: busy=0, tx=1. If ~fifo_empty, go to FETCH.
  - FETCH: fifo_rd=1, busy=1. Stay while rd_acc=0 (write collision stall). On rd_acc=1, go to LOAD.
  - LOAD (1 cycle): capture fifo_dout into the shift register and clear the baud counter. Go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles, then shift right and increment the index. After index 7, go to STOP (or PARITY when the option is enabled).
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then go to FETCH if ~fifo_empty (back-to-back frames, no idle bit), else to IDLE.
- tx is registered. It changes on the clock edge that enters START, each DATA bit, and STOP.
- Baud counter width is $clog2(CLKS_PER_BIT). The bit period ends when the counter equals CLKS_PER_BIT-1; the counter then wraps to 0.
- Latency: ~fifo_empty seen in IDLE → fifo_rd high next cycle → start bit begins 2 cycles after acceptance.
- busy is high in FETCH, LOAD, START, DATA, PARITY and STOP.
- Frame length: 10*CLKS_PER_BIT cycles; 11*CLKS_PER_BIT with parity.
- Reset mid-frame: the frame is aborted, tx returns to 1 on the next edge, and any byte already popped is lost.
- The FIFO cannot go empty while this block is in FETCH, because only this block reads it. The block requires no empty-abort path.

Optional Feature:
UART_TX_PARITY_EN
- Defined: adds a PARITY state between DATA and STOP. tx = XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles.
- Undefined: no PARITY state; 8N1 framing; the parity logic is absent.

Decomposition:
- Package uart_pkg: state enum (IDLE, FETCH, LOAD, START, DATA, PARITY, STOP), UART_IDLE_LVL=1'b1, START_LVL=1'b0, and the bits-per-frame constants.
- Sub-module uart_baud_cnt:
  - Parameterised by CLKS_PER_BIT; inputs clear and enable.
  - Outputs a bit_done pulse.
  - Instantiated once.

Test Plan:
- Reset and idle: assert rst, fifo_empty=1. Expect tx=1, busy=0, fifo_rd=0 constantly for 50 cycles.
- Single byte 0xA5, CLKS_PER_BIT=4:
  - fifo_rd pulses for 1 cycle.
  - tx sequence is 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles.
  - busy falls after 40 cycles of frame; the FIFO ends empty.
- Back-to-back: the FIFO holds 0x00, 0xFF, 0x3C. Expect three contiguous frames with no idle high between the stop bit and the next start bit apart from the FETCH and LOAD cycles (2 cycles).
- Write collision: hold fifo_wr=1, fifo_full=0 for 5 cycles while in FETCH. Expect fifo_rd held high 6 cycles, no LOAD until fifo_wr drops, and the correct byte transmitted.
- Reset mid-frame: assert rst during data bit 3 of 0x81. Expect tx=1 and busy=0 on the next edge, then a fresh frame of the next FIFO byte after release.
- Parity with UART_TX_PARITY_EN, bytes 0x07 and 0x03: expect parity bits 1 and 0 respectively before the stop bit, and frame length 44 cycles.
